// File: rtl/control_sequencer.sv
// control_sequencer: hardwired Moore control FSM for the Mini SRC datapath.
// Sequences fetch, decode and 3-register ALU execute, and counts retired instructions.
module control_sequencer #(
   parameter int OPW  = 5,
   parameter int CNTW = 16
) (
   input  logic            i_clock,
   input  logic            i_clear,
   input  logic            i_run,
   input  logic [31:0]     i_ir,
   input  logic            i_mem_rdy,
   output logic            o_pc_out,
   output logic            o_zlow_out,
   output logic            o_mdr_out,
   output logic            o_r_out,
   output logic            o_mar_in,
   output logic            o_z_in,
   output logic            o_pc_in,
   output logic            o_mdr_in,
   output logic            o_ir_in,
   output logic            o_y_in,
   output logic            o_r_in,
   output logic            o_inc_pc,
   output logic            o_read,
   output logic            o_gra,
   output logic            o_grb,
   output logic            o_grc,
   output logic [3:0]      o_alu_op,
   output logic            o_done,
   output logic            o_halted,
   output logic            o_illegal_op,
   output logic [CNTW-1:0] o_instr_count
);

   localparam logic [3:0] S_IDLE = 4'd0;
   localparam logic [3:0] S_T0   = 4'd1;
   localparam logic [3:0] S_T1   = 4'd2;
   localparam logic [3:0] S_T2   = 4'd3;
   localparam logic [3:0] S_T3   = 4'd4;
   localparam logic [3:0] S_T4   = 4'd5;
   localparam logic [3:0] S_T5   = 4'd6;
   localparam logic [3:0] S_T6   = 4'd7;
   localparam logic [3:0] S_HALT = 4'd8;

   localparam logic [OPW-1:0] OP_ADD  = OPW'(5'b00011);
   localparam logic [OPW-1:0] OP_SUB  = OPW'(5'b00100);
   localparam logic [OPW-1:0] OP_AND  = OPW'(5'b00101);
   localparam logic [OPW-1:0] OP_OR   = OPW'(5'b00110);
   localparam logic [OPW-1:0] OP_NOP  = OPW'(5'b11010);
   localparam logic [OPW-1:0] OP_HALT = OPW'(5'b11011);

   logic [3:0]      r_state;
   logic            r_t1_wait;
   logic [CNTW-1:0] r_instr_count;

   logic [3:0]     w_next;
   logic [OPW-1:0] w_op;
   logic           w_is_alu, w_is_nop, w_is_halt;
   logic [3:0]     w_alu_code;
   logic           w_unused_ir;
   logic w_pc_out, w_zlow_out, w_mdr_out, w_r_out, w_mar_in, w_z_in, w_pc_in;
   logic w_mdr_in, w_ir_in, w_y_in, w_r_in, w_inc_pc, w_read, w_gra, w_grb, w_grc;
   logic w_done, w_halted, w_illegal;
   logic [3:0] w_alu_op;

   // Register fields only steer the datapath through Gra/Grb/Grc, never the sequencing.
   assign w_op        = i_ir[31 -: OPW];
   assign w_unused_ir = ^i_ir[31-OPW:0];
   assign w_is_nop    = (w_op == OP_NOP);
   assign w_is_halt   = (w_op == OP_HALT);

   // Opcode class and ALU function decode.
   always_comb begin
      w_is_alu   = 1'b0;
      w_alu_code = 4'd0;
      case (w_op)
         OP_ADD:  begin w_is_alu = 1'b1; w_alu_code = 4'd1; end
         OP_SUB:  begin w_is_alu = 1'b1; w_alu_code = 4'd2; end
         OP_AND:  begin w_is_alu = 1'b1; w_alu_code = 4'd3; end
         OP_OR:   begin w_is_alu = 1'b1; w_alu_code = 4'd4; end
         default: begin w_is_alu = 1'b0; w_alu_code = 4'd0; end
      endcase
   end

   // Moore strobe decode and next-state selection.
   always_comb begin
      w_next = r_state;
      {w_pc_out, w_zlow_out, w_mdr_out, w_r_out, w_mar_in, w_z_in, w_pc_in} = 7'd0;
      {w_mdr_in, w_ir_in, w_y_in, w_r_in, w_inc_pc, w_read, w_gra, w_grb, w_grc} = 9'd0;
      {w_done, w_halted, w_illegal} = 3'd0;
      w_alu_op = 4'd0;
      case (r_state)
         S_IDLE: begin
            if (i_run) w_next = S_T0;
            else       w_next = S_IDLE;
         end
         S_T0: begin
            {w_pc_out, w_mar_in, w_inc_pc, w_z_in} = 4'b1111;
            w_next = S_T1;
         end
         S_T1: begin
            // PC update only once even when memory stalls.
            {w_zlow_out, w_read, w_mdr_in} = 3'b111;
            w_pc_in = ~r_t1_wait;
            if (i_mem_rdy) w_next = S_T2;
            else           w_next = S_T1;
         end
         S_T2: begin
            {w_mdr_out, w_ir_in} = 2'b11;
            w_next = S_T3;
         end
         S_T3: begin
            if (w_is_alu) begin
               w_next = S_T4;
            end else if (w_is_halt) begin
               w_next = S_HALT;
            end else begin
               w_done    = 1'b1;
               w_illegal = ~w_is_nop;
               w_next    = i_run ? S_T0 : S_IDLE;
            end
         end
         S_T4: begin
            {w_grb, w_r_out, w_y_in} = 3'b111;
            w_next = S_T5;
         end
         S_T5: begin
            {w_grc, w_r_out, w_z_in} = 3'b111;
            w_alu_op = w_alu_code;
            w_next   = S_T6;
         end
         S_T6: begin
            {w_zlow_out, w_gra, w_r_in, w_done} = 4'b1111;
            w_next = i_run ? S_T0 : S_IDLE;
         end
         S_HALT: begin
            w_halted = 1'b1;
            w_next   = S_HALT;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // State, T1 stall flag and retired-instruction counter.
   always_ff @(posedge i_clock or negedge i_clear) begin
      if (!i_clear) begin
         r_state       <= S_IDLE;
         r_t1_wait     <= 1'b0;
         r_instr_count <= '0;
      end else begin
         r_state   <= w_next;
         r_t1_wait <= (r_state == S_T1) && !i_mem_rdy;
         if (w_done) r_instr_count <= r_instr_count + CNTW'(1);
         else        r_instr_count <= r_instr_count;
      end
   end

   assign o_pc_out      = w_pc_out;
   assign o_zlow_out    = w_zlow_out;
   assign o_mdr_out     = w_mdr_out;
   assign o_r_out       = w_r_out;
   assign o_mar_in      = w_mar_in;
   assign o_z_in        = w_z_in;
   assign o_pc_in       = w_pc_in;
   assign o_mdr_in      = w_mdr_in;
   assign o_ir_in       = w_ir_in;
   assign o_y_in        = w_y_in;
   assign o_r_in        = w_r_in;
   assign o_inc_pc      = w_inc_pc;
   assign o_read        = w_read;
   assign o_gra         = w_gra;
   assign o_grb         = w_grb;
   assign o_grc         = w_grc;
   assign o_alu_op      = w_alu_op;
   assign o_done        = w_done;
   assign o_halted      = w_halted;
   assign o_illegal_op  = w_illegal;
   assign o_instr_count = r_instr_count;

endmodule
